mem_stage: RTL

- MEM pipeline stage; consumes the EX/MEM register outputs (M_*) and drives the data-memory request/grant/response bus.
- Stalls the pipeline until each load or store completes.
- Aligns and sign- or zero-extends load data.
- Registers the result into the MEM/WB boundary (W_*) for writeback.

---
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Data-memory request/grant/response bus between the MEM stage and the memory.
interface mem_stage_if;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_wmask;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;

   modport master (
      output dm_req, dm_we, dm_addr, dm_wdata, dm_wmask,
      input  dm_gnt, dm_rvalid, dm_rdata
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_wmask,
      output dm_gnt, dm_rvalid, dm_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses, stalls until completion or
// timeout, formats load data and registers the MEM/WB boundary.
module mem_stage #(
   parameter int MAX_WAIT = 255,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        M_rd,
   input  logic [2:0]        M_funct3,
   input  logic              M_reg_write_enable,
   input  logic              M_wb_data_sel,
   input  logic              M_web,
   input  logic [DATA_W-1:0] M_dm_write_enable,
   input  logic [DATA_W-1:0] M_alu_out,
   input  logic [DATA_W-1:0] M_dm_data,
   mem_stage_if.master       dm,
   output logic              mem_stall,
   output logic              mem_err,
   output logic [4:0]        W_rd,
   output logic              W_reg_write_enable,
   output logic [DATA_W-1:0] W_wb_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

   state_t      state_r;
   state_t      state_next_s;
   logic [15:0] wait_cnt_r;
   logic [15:0] wait_cnt_next_s;

   logic is_store_s;
   logic is_load_s;
   logic access_s;
   logic issuing_s;
   logic store_done_s;
   logic load_done_s;
   logic timeout_s;
   logic complete_s;
   logic [DATA_W-1:0] wb_value_s;

   function automatic logic [31:0] format_load(
      input logic [2:0]  funct3,
      input logic [1:0]  off,
      input logic [31:0] word
   );
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (funct3)
         3'b000:  format_load = {{24{b[7]}}, b};
         3'b001:  format_load = {{16{h[15]}}, h};
         3'b010:  format_load = word;
         3'b100:  format_load = {24'h000000, b};
         3'b101:  format_load = {16'h0000, h};
         default: format_load = 32'h0000_0000;
      endcase
   endfunction

   // Access classification and completion; a store wins if both flags are set.
   always_comb begin
      is_store_s   = ~M_web;
      is_load_s    = M_wb_data_sel & M_web;
      access_s     = is_store_s | is_load_s;
      issuing_s    = access_s & ((state_r == IDLE) | (state_r == REQ));
      store_done_s = issuing_s & is_store_s & dm.dm_gnt;
      load_done_s  = (state_r == RESP) & dm.dm_rvalid;
      timeout_s    = (state_r != IDLE) & (wait_cnt_r == WAIT_LAST) & ~store_done_s & ~load_done_s;
      complete_s   = store_done_s | load_done_s | timeout_s;
   end

   // Next-state and wait-counter logic.
   always_comb begin
      state_next_s    = state_r;
      wait_cnt_next_s = wait_cnt_r;
      case (state_r)
         IDLE: begin
            if (!access_s) begin
               state_next_s = IDLE;
            end else if (is_store_s) begin
               state_next_s = dm.dm_gnt ? IDLE : REQ;
            end else begin
               state_next_s = dm.dm_gnt ? RESP : REQ;
            end
         end
         REQ: begin
            if (timeout_s || !access_s) begin
               state_next_s = IDLE;
            end else if (dm.dm_gnt) begin
               state_next_s = is_store_s ? IDLE : RESP;
            end else begin
               state_next_s = REQ;
            end
         end
         RESP: begin
            if (load_done_s || timeout_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = RESP;
            end
         end
         default: state_next_s = IDLE;
      endcase
      // Counter holds the number of cycles since the first dm_req cycle.
      if (state_next_s == IDLE) begin
         wait_cnt_next_s = 16'd0;
      end else if (state_r == IDLE) begin
         wait_cnt_next_s = 16'd1;
      end else begin
         wait_cnt_next_s = wait_cnt_r + 16'd1;
      end
   end

   // FSM state and wait counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         wait_cnt_r <= 16'd0;
      end else begin
         state_r    <= state_next_s;
         wait_cnt_r <= wait_cnt_next_s;
      end
   end

   // Bus and pipeline-control outputs, all forced low while in reset.
   always_comb begin
      if (rst) begin
         dm.dm_req    = 1'b0;
         dm.dm_we     = 1'b0;
         dm.dm_addr   = 32'h0000_0000;
         dm.dm_wdata  = 32'h0000_0000;
         dm.dm_wmask  = 32'h0000_0000;
         mem_stall    = 1'b0;
         mem_err      = 1'b0;
      end else begin
         dm.dm_req    = issuing_s;
         dm.dm_we     = issuing_s & is_store_s;
         dm.dm_addr   = {M_alu_out[31:2], 2'b00};
         dm.dm_wdata  = M_dm_data;
         dm.dm_wmask  = M_dm_write_enable;
         mem_stall    = access_s & ~complete_s;
         mem_err      = timeout_s;
      end
   end

   // Writeback value: aborted loads return zero.
   always_comb begin
      if (!is_load_s) begin
         wb_value_s = M_alu_out;
      end else if (timeout_s) begin
         wb_value_s = 32'h0000_0000;
      end else begin
         wb_value_s = format_load(M_funct3, M_alu_out[1:0], dm.dm_rdata);
      end
   end

   // MEM/WB boundary register; a stall inserts a bubble and holds rd/data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         W_rd               <= 5'd0;
         W_reg_write_enable <= 1'b0;
         W_wb_data          <= 32'h0000_0000;
      end else if (mem_stall) begin
         W_reg_write_enable <= 1'b0;
      end else begin
         W_rd               <= M_rd;
         W_reg_write_enable <= M_reg_write_enable & (M_rd != 5'd0);
         W_wb_data          <= wb_value_s;
      end
   end

endmodule
